// File: rtl/expr_pkg.sv
// Field layout shared by the expression-result packer, unpacker and checker blocks.
// Each 30-bit group packs the fields u4, u5, u6, s4, s5, s6, MSB first.
package expr_pkg;

    localparam int FIELD_GRP_BITS = 30;
    localparam int FIELDS_PER_GRP = 6;
    localparam int MAX_FIELD_W    = 6;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [2:0] field_width(input logic [4:0] k);
        return 3'd4 + 3'(k % 5'd3);
    endfunction

    function automatic logic field_is_signed(input logic [4:0] k);
        return (k % 5'd6) >= 5'd3;
    endfunction

endpackage

// File: rtl/field_extend.sv
// Widens one MSB-aligned raw field (4..6 bits) to OUT_W bits.
// The field is sign-extended when it is signed and zero-filled otherwise.
module field_extend
    import expr_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [MAX_FIELD_W-1:0] raw,
    input  logic [2:0]             width,
    input  logic                   is_signed,
    output logic [OUT_W-1:0]       ext
);

    logic [MAX_FIELD_W-1:0]        val;
    logic [MAX_FIELD_W-1:0]        fill;
    logic signed [MAX_FIELD_W-1:0] sval;
    logic                          neg;

    always_comb begin
        // The field arrives left-justified; bring it down to bit 0 first.
        val  = raw >> (3'd6 - width);
        fill = {MAX_FIELD_W{1'b1}} << width;
        neg  = is_signed && val[width - 3'd1];
        sval = signed'(val | fill);
        if (neg) begin
            ext = OUT_W'(sval);
        end else begin
            ext = OUT_W'(val);
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Splits a packed expression-result word into one extended field per beat,
// with zero-bubble chaining from the last field of one word to the next word.
module expr_result_unpacker
    import expr_pkg::*;
#(
    parameter int NUM_GROUPS = 3,
    parameter int OUT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FIELD_GRP_BITS*NUM_GROUPS-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_W-1:0]                     out_field,
    output logic [4:0]                           out_idx,
    output logic                                 out_signed,
    output logic                                 out_last
);

    localparam int         DW       = FIELD_GRP_BITS * NUM_GROUPS;
    localparam int         NF       = FIELDS_PER_GRP * NUM_GROUPS;
    localparam logic [4:0] LAST_IDX = 5'(NF - 1);

    state_t            state;
    logic [DW-1:0]     shreg;
    logic [4:0]        idx;
    logic [2:0]        cur_w;
    logic              cur_s;
    logic [OUT_W-1:0]  ext;
    logic              xfer_out;
    logic              load;

    assign cur_w = field_width(idx);
    assign cur_s = field_is_signed(idx);

    // Every output is decoded from state/idx/shreg, so nothing reaches out_valid from out_ready.
    assign out_valid  = (state == EMIT);
    assign out_last   = out_valid && (idx == LAST_IDX);
    assign out_idx    = idx;
    assign out_signed = out_valid && cur_s;
    assign out_field  = out_valid ? ext : '0;

    assign xfer_out = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (xfer_out && out_last);
    assign load     = in_valid && in_ready;

    field_extend #(
        .OUT_W(OUT_W)
    ) u_field_extend (
        .raw      (shreg[DW-1 -: MAX_FIELD_W]),
        .width    (cur_w),
        .is_signed(cur_s),
        .ext      (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= in_data;
            idx   <= '0;
            state <= EMIT;
        end else if (xfer_out) begin
            shreg <= shreg << cur_w;
            if (out_last) begin
                idx   <= '0;
                state <= IDLE;
            end else begin
                idx <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Self-checking bench for expr_result_unpacker against a bit-position reference model.
module tb_expr_result_unpacker;

    localparam int DW    = 90;
    localparam int NF    = 18;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_field;
    logic [4:0]       out_idx;
    logic             out_signed;
    logic             out_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] obs_field[$];
    int               obs_idx[$];
    bit               obs_signed[$];
    bit               obs_last[$];
    int               hold_viol;
    int               first_lat;
    bit               inready_last;
    bit               valid_after;

    expr_result_unpacker #(.NUM_GROUPS(3), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_idx   (out_idx),
        .out_signed(out_signed),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Reference: walk the word MSB first by field width, then apply two's-complement meaning.
    function automatic logic [OUT_W-1:0] model_field(input logic [DW-1:0] w, input int k);
        int            pos;
        int            wdt;
        int            v;
        logic [DW-1:0] t;
        pos = 0;
        for (int j = 0; j < k; j++) pos += 4 + j % 3;
        wdt = 4 + k % 3;
        t = w >> (DW - pos - wdt);
        v = int'(t[5:0]) & ((1 << wdt) - 1);
        if ((k % 6) >= 3 && v >= (1 << (wdt - 1))) v -= (1 << wdt);
        return OUT_W'(v);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    // Stimulus driver: loads one word from IDLE and collects accepted beats.
    task automatic run_frame(input logic [DW-1:0] word, input int mode, output bit timeout);
        int               cyc;
        int               phase;
        bit               held;
        logic [OUT_W-1:0] hf;
        logic [4:0]       hi;
        logic             hs;
        logic             hl;
        obs_field.delete();
        obs_idx.delete();
        obs_signed.delete();
        obs_last.delete();
        hold_viol = 0;
        first_lat = -1;
        inready_last = 1'b0;
        held = 1'b0;
        hf = '0; hi = '0; hs = 1'b0; hl = 1'b0;
        phase = 0;
        cyc = 0;
        @(negedge clk);
        in_data = word;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = rand_word();
        while (obs_field.size() < NF && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (out_valid) begin
                if (first_lat < 0) first_lat = cyc;
                if (held && (out_field !== hf || out_idx !== hi || out_signed !== hs || out_last !== hl))
                    hold_viol++;
                if (out_ready) begin
                    obs_field.push_back(out_field);
                    obs_idx.push_back(int'(out_idx));
                    obs_signed.push_back(out_signed);
                    obs_last.push_back(out_last);
                    if (out_last) inready_last = in_ready;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hf = out_field; hi = out_idx; hs = out_signed; hl = out_last;
                end
                phase++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        valid_after = out_valid;
        timeout = (obs_field.size() < NF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_field, out_idx, out_signed, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b f=%h i=%0d s=%b l=%b required all zero",
                     out_valid, out_field, out_idx, out_signed, out_last);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_all_ones();
        logic [OUT_W-1:0] tbl [6];
        bit               to;
        tbl = '{8'h0F, 8'h1F, 8'h3F, 8'hFF, 8'hFF, 8'hFF};
        run_frame({DW{1'b1}}, 0, to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_timeout got %0d beats required %0d", obs_field.size(), NF);
        end
        for (int k = 0; k < obs_field.size(); k++) begin
            n_checks++;
            if (obs_field[k] !== tbl[k % 6] || obs_idx[k] !== k || obs_last[k] !== (k == NF - 1) ||
                obs_signed[k] !== ((k % 6) >= 3)) begin
                n_fail++;
                $display("FAIL ones_field k=%0d got f=%h i=%0d l=%b s=%b required f=%h",
                         k, obs_field[k], obs_idx[k], obs_last[k], obs_signed[k], tbl[k % 6]);
            end
        end
        n_checks++;
        if (first_lat !== 0) begin
            n_fail++;
            $display("FAIL ones_latency got %0d required 0", first_lat);
        end
        n_checks++;
        if (inready_last !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_in_ready_at_last got %b required 1", inready_last);
        end
        n_checks++;
        if (valid_after !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_extra_beat got out_valid=%b required 0", valid_after);
        end
    endtask

    task automatic test_probe();
        logic [DW-1:0] w;
        bit            to;
        for (int p = 0; p < 2; p++) begin
            w = '0;
            if (p == 0) w[74:71] = 4'b1000;
            else        w[80:75] = 6'b100000;
            run_frame(w, 0, to);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL probe_timeout p=%0d got %0d beats required %0d", p, obs_field.size(), NF);
            end
            for (int k = 0; k < obs_field.size(); k++) begin
                logic [OUT_W-1:0] e;
                e = (p == 0 && k == 3) ? 8'hF8 : (p == 1 && k == 2) ? 8'h20 : 8'h00;
                n_checks++;
                if (obs_field[k] !== e || obs_signed[k] !== ((k % 6) >= 3)) begin
                    n_fail++;
                    $display("FAIL probe_field p=%0d k=%0d got f=%h s=%b required f=%h",
                             p, k, obs_field[k], obs_signed[k], e);
                end
            end
        end
    endtask

    task automatic test_signed_boundary();
        logic [DW-1:0] w;
        bit            to;
        w = rand_word();
        w[85:81] = 5'b10000;
        w[70:66] = 5'b01111;
        w[65:60] = 6'b100000;
        run_frame(w, 0, to);
        n_checks++;
        if (to !== 1'b0 || obs_field[1] !== 8'h10 || obs_field[4] !== 8'h0F || obs_field[5] !== 8'hE0) begin
            n_fail++;
            $display("FAIL signed_boundary got u5=%h s5=%h s6=%h required 10 0f e0",
                     obs_field[1], obs_field[4], obs_field[5]);
        end
        for (int k = 0; k < obs_field.size(); k++) begin
            n_checks++;
            if (obs_field[k] !== model_field(w, k)) begin
                n_fail++;
                $display("FAIL signed_word k=%0d got %h required %h", k, obs_field[k], model_field(w, k));
            end
        end
    endtask

    task automatic test_backpressure();
        bit            to;
        logic [DW-1:0] w;
        for (int r = 0; r < 4; r++) begin
            w = rand_word();
            run_frame(w, (r == 0) ? 1 : 2, to);
            n_checks++;
            if (to !== 1'b0 || hold_viol !== 0 || valid_after !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure r=%0d got beats=%0d hold_viol=%0d trailing_valid=%b required %0d,0,0",
                         r, obs_field.size(), hold_viol, valid_after, NF);
            end
            for (int k = 0; k < obs_field.size(); k++) begin
                n_checks++;
                if (obs_field[k] !== model_field(w, k) || obs_idx[k] !== k) begin
                    n_fail++;
                    $display("FAIL backpressure_field r=%0d k=%0d got f=%h i=%0d required f=%h i=%0d",
                             r, k, obs_field[k], obs_idx[k], model_field(w, k), k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
        bit               v[2*NF];
        logic [OUT_W-1:0] f[2*NF];
        int               ix[2*NF];
        bit               rdy5;
        a = rand_word();
        b = ~a;
        rdy5 = 1'b1;
        @(negedge clk);
        in_data = a;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = b;
        for (int c = 0; c < 2 * NF; c++) begin
            #1;
            v[c] = out_valid;
            f[c] = out_field;
            ix[c] = int'(out_idx);
            if (c == 5) rdy5 = in_ready;
            if (c == NF) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (rdy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_mid_word got %b required 0", rdy5);
        end
        for (int c = 0; c < 2 * NF; c++) begin
            logic [OUT_W-1:0] e;
            e = (c < NF) ? model_field(a, c) : model_field(b, c - NF);
            n_checks++;
            if (v[c] !== 1'b1 || f[c] !== e || ix[c] !== c % NF) begin
                n_fail++;
                $display("FAIL b2b_beat c=%0d got v=%b f=%h i=%0d required v=1 f=%h i=%0d",
                         c, v[c], f[c], ix[c], e, c % NF);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_trailing got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] w;
        bit            to;
        @(negedge clk);
        in_data = rand_word();
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_checks++;
        if (out_idx !== 5'd8 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_position got v=%b i=%0d required v=1 i=8", out_valid, out_idx);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_field, out_idx, out_signed, out_last} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async got v=%b f=%h i=%0d s=%b l=%b required all zero",
                     out_valid, out_field, out_idx, out_signed, out_last);
        end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        w = rand_word();
        run_frame(w, 0, to);
        n_checks++;
        if (to !== 1'b0 || first_lat !== 0) begin
            n_fail++;
            $display("FAIL midrst_restart got beats=%0d lat=%0d required %0d lat 0", obs_field.size(), first_lat, NF);
        end
        for (int k = 0; k < obs_field.size(); k++) begin
            n_checks++;
            if (obs_field[k] !== model_field(w, k) || obs_idx[k] !== k) begin
                n_fail++;
                $display("FAIL midrst_field k=%0d got f=%h i=%0d required f=%h i=%0d",
                         k, obs_field[k], obs_idx[k], model_field(w, k), k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_probe();
        test_signed_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_result_unpacker.md
Name: expr_result_unpacker

Overview:
- Consumes the 90-bit packed result word that the generated expression blocks produce ({y0..y17}, y0 in the MSBs) and emits one field per beat over a valid/ready stream.
- Each field is sign- or zero-extended to OUT_W bits according to its declared signedness.
- Sits between the DUT output capture and the regression scoreboard, so field-level compare needs no per-test slicing logic.

Parameters:
- NUM_GROUPS, 3, number of 30-bit groups; word width DW = 30*NUM_GROUPS, field count NF = 6*NUM_GROUPS.
- OUT_W, 8, output field width; must be >= 6.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  packed word available.
- in_ready  out  1  unpacker can accept a word.
- in_data  in  DW  packed word; field 0 at [DW-1 -: 4].
- out_valid  out  1  out_field valid.
- out_ready  in  1  consumer accepts field.
- out_field  out  OUT_W  extended field value.
- out_idx  out  5  field index 0..NF-1.
- out_signed  out  1  field k is signed.
- out_last  out  1  asserted with field NF-1.

Behaviour:
- Field layout for field k, MSB first:
  - width = 4 + (k mod 3).
  - signed when (k mod 6) >= 3.
  - Pattern per group: u4, u5, u6, s4, s5, s6.
- Handshake: a transfer occurs on a cycle where valid && ready. out_valid, out_field, out_idx, out_signed and out_last must stay stable while out_valid && !out_ready.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch in_data into the shift register, set idx=0, go to EMIT.
  - EMIT: out_valid=1. out_field = extend(shreg[DW-1 -: width(idx)]). On out_ready:
    - shift shreg left by width(idx) and increment idx;
    - if idx == NF-1, go to IDLE.
- Zero-bubble chaining: in_ready is also high in EMIT on a cycle where out_valid && out_ready && out_last. If in_valid is high that cycle, load the new word and stay in EMIT with idx=0. Field 0 of the new word is valid on the next cycle.
- Latency: field 0 valid one cycle after input acceptance. A full word takes NF cycles under continuous out_ready.
- in_valid in EMIT (other than on the last-field handshake) is ignored. The input word is not consumed and in_data is not sampled.
- Extension:
  - signed fields replicate bit width-1 up to OUT_W;
  - unsigned fields zero-fill;
  - no truncation occurs since OUT_W >= 6.
- Reset, asynchronous, including mid-frame: state=IDLE, shreg=0, idx=0, out_valid=0, out_field=0, out_idx=0, out_signed=0, out_last=0. Any partially emitted word is discarded and no remaining fields are produced. in_ready=1 once rst deasserts.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready to out_valid; in_ready depends on out_ready only through the chaining term.

Decomposition:
- Shared package expr_pkg holds:
  - FIELD_GRP_BITS=30 and FIELDS_PER_GRP=6;
  - function field_width(k) and function field_is_signed(k);
  - typedef of state enum {IDLE, EMIT}.
  - The future packer/checker blocks reuse it.
- One sub-module: field_extend, combinational. Takes raw[5:0], width[2:0] and is_signed; produces OUT_W bits.
- FSM, index counter and shift register stay in the top module.

Test Plan:
- All-ones word with out_ready=1: 18 beats. idx 0,1,2 give 0x0F,0x1F,0x3F; idx 3,4,5 give 0xFF. The pattern repeats. out_last only at idx 17. in_ready returns high at the cycle of the idx-17 handshake.
- Single-field probe: word with only y3 = 4'b1000 (bits [74:71]) and all other bits 0. idx 3 gives 0xF8 with out_signed=1; all other fields give 0x00. Same probe with y2 = 6'b100000 gives 0x20 at idx 2.
- Backpressure: toggle out_ready 1,0,0,1 on every field. Each field is held stable across stalls, no field is lost or duplicated, and total beats = 18.
- Back-to-back: two words presented continuously. Word B field 0 appears the cycle after word A idx 17 handshakes, with no idle cycle between. A second in_valid held during A idx 5 is not consumed.
- Reset mid-frame: assert rst after idx 7 handshakes. Outputs are zero immediately, without waiting for a clock edge. After release, the next word starts at idx 0 and no stale fields appear.
- Signed boundary: s5 field = 5'b01111 gives 0x0F; s6 field = 6'b100000 gives 0xE0; u5 field = 5'b10000 gives 0x10.
